inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/inst_fetch.sv | 163 ++++++++++++++++
 tb/tb_inst_fetch.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared fetch/decode definitions: instruction width constants, the NOP
// encoding, major opcodes and the fetch-buffer entry layout.
package inst_fetch_pkg;

  localparam int XLEN = 64;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] ALGORITHM     = 7'b0110011;
  localparam logic [6:0] ALGORITHM_IMM = 7'b0010011;
  localparam logic [6:0] LOAD          = 7'b0000011;
  localparam logic [6:0] BRANCH        = 7'b1100011;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two circular buffer holding fetched {instruction, pc} pairs.
// Synchronous flush, asynchronous active-low reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 96
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & (count_q != '0);
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: credit-limited request issue, in-order response buffering,
// branch redirect with discard of in-flight responses. Define IFETCH_PERF_CNT_EN
// to add the fetch_cnt / flush_cnt performance counters.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] PC_o,
  output logic            inst_valid
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(FIFO_DEPTH);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             req_q, req_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      inst_q, inst_d;
  logic [XLEN-1:0]  pc_out_q, pc_out_d;
  logic             valid_q, valid_d;

  logic             accept, resp_drop, resp_keep, out_take;
  logic             fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0] fifo_count, occupancy_d, in_flight;
  fetch_entry_t     fifo_wr, fifo_rd, head;
  logic [XLEN-1:0]  target_aligned;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (reset),
    .flush     (branch_taken),
    .push      (fifo_push),
    .push_data (fifo_wr),
    .pop       (fifo_pop),
    .pop_data  (fifo_rd),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // An empty buffer lets a fresh response bypass straight to the output stage.
  always_comb begin
    target_aligned = word_align(branch_target);
    accept    = req_q & imem_ready;
    resp_drop = imem_rvalid & (discard_q != '0);
    resp_keep = imem_rvalid & (discard_q == '0) & (outstanding_q != '0);
    out_take  = ~stall & ~branch_taken & (~fifo_empty | resp_keep);
    fifo_pop  = out_take & ~fifo_empty;
    fifo_push = resp_keep & ~branch_taken & ~(out_take & fifo_empty);
    fifo_wr   = '{inst: imem_rdata, pc: resp_pc_q};
    head      = fifo_empty ? fifo_wr : fifo_rd;
    in_flight = outstanding_q + CNT_W'(accept) - CNT_W'(resp_keep);

    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = in_flight;
    discard_d     = discard_q - CNT_W'(resp_drop);
    occupancy_d   = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    inst_d        = inst_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;

    if (accept)    pc_d      = pc_q + 64'd4;
    if (resp_keep) resp_pc_d = resp_pc_q + 64'd4;

    if (branch_taken) begin
      pc_d          = target_aligned;
      resp_pc_d     = target_aligned;
      discard_d     = discard_d + in_flight;
      outstanding_d = '0;
      occupancy_d   = '0;
      inst_d        = NOP_INST;
      valid_d       = 1'b0;
    end else if (!stall) begin
      if (out_take) begin
        inst_d   = head.inst;
        pc_out_d = head.pc;
        valid_d  = 1'b1;
      end else begin
        inst_d  = NOP_INST;
        valid_d = 1'b0;
      end
    end

    // Only request when every response already owed has a guaranteed slot.
    req_d = (discard_d == '0) &&
            (({1'b0, outstanding_d} + {1'b0, occupancy_d}) < DEPTH_LIM);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      req_q         <= 1'b0;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      inst_q        <= NOP_INST;
      pc_out_q      <= RESET_PC;
      valid_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      req_q         <= req_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      inst_q        <= inst_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign PC_o       = pc_out_q;
  assign inst_valid = valid_q;

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 32'(out_take);
    flush_cnt_d = flush_cnt_q + 32'(branch_taken);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: an in-order memory model feeds the fetcher while a
// program-order model predicts every instruction that reaches decode.
module tb_inst_fetch;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK, reset, stall, branch_taken, imem_ready, imem_rvalid;
  logic [63:0] branch_target;
  logic [31:0] imem_rdata;
  logic        imem_req, inst_valid;
  logic [63:0] imem_addr, PC_o;
  logic [31:0] inst;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  inst_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .PC_o          (PC_o),
    .inst_valid    (inst_valid)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .flush_cnt     (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] memQ[$];
  int          staleLeft;
  logic [63:0] expPc;
  int          delivered;
  int          fetchModel, flushModel;
  logic        prevStall, prevBranch, prevReq, prevReady, prevValid;
  logic [63:0] prevTarget, prevAddr, prevPc;
  logic [31:0] prevInst;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h0) return 32'h0010_0093;
    if (a == 64'h4) return 32'h0020_0113;
    return 32'hC000_0000 | a[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Program-order expectations for the cycle that just completed.
  task automatic modelCheck();
    if (prevBranch) begin
      checkOutput("branchInst", inst, NOP);
      checkOutput("branchValid", inst_valid, 0);
      checkOutput("branchAddr", imem_addr, prevTarget & ~64'h3);
      expPc = prevTarget & ~64'h3;
      flushModel++;
    end else begin
      if (prevStall) begin
        checkOutput("stallInst", inst, prevInst);
        checkOutput("stallPc", PC_o, prevPc);
        checkOutput("stallValid", inst_valid, prevValid);
      end else if (inst_valid) begin
        checkOutput("orderPc", PC_o, expPc);
        checkOutput("orderInst", inst, memWord(expPc));
        expPc = expPc + 64'd4;
        delivered++;
        fetchModel++;
      end else begin
        checkOutput("bubbleInst", inst, NOP);
        checkOutput("bubblePc", PC_o, prevPc);
      end
      checkOutput("addrStep", imem_addr, prevAddr + ((prevReq && prevReady) ? 64'd4 : 64'd0));
      if (prevReq && !prevReady) checkOutput("reqHeld", imem_req, 1);
    end
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("fetchCnt", fetch_cnt, fetchModel);
    checkOutput("flushCnt", flush_cnt, flushModel);
`endif
  endtask

  // One clock cycle: drive inputs, play the memory, advance, then check.
  task automatic applyStimulus(input logic stallIn, input logic branchIn,
                               input logic [63:0] targetIn, input logic readyIn,
                               input int respMode);
    logic acc;
    acc = imem_req && readyIn;
    stall = stallIn;
    branch_taken = branchIn;
    branch_target = targetIn;
    imem_ready = readyIn;
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    if (acc) checkOutput("reqDuringDiscard", staleLeft, 0);
    if (memQ.size() > 0) begin
      if (respMode == 1 || (respMode == 2 && $urandom_range(0, 1) == 1)) begin
        imem_rvalid = 1'b1;
        imem_rdata = memWord(memQ.pop_front());
        if (staleLeft > 0) staleLeft--;
      end
    end else if (respMode == 1 || (respMode == 2 && $urandom_range(0, 7) == 0)) begin
      imem_rvalid = 1'b1;
    end
    if (acc) memQ.push_back(imem_addr);
    checkOutput("inflightBound", memQ.size() <= DEPTH, 1);
    if (branchIn) staleLeft = memQ.size();
    prevStall = stallIn;
    prevBranch = branchIn;
    prevTarget = targetIn;
    prevReady = readyIn;
    prevReq = imem_req;
    prevAddr = imem_addr;
    prevPc = PC_o;
    prevInst = inst;
    prevValid = inst_valid;
    @(posedge CLK);
    #1;
    modelCheck();
  endtask

  task automatic resetDut();
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    #2;
    checkOutput("rstReq", imem_req, 0);
    checkOutput("rstAddr", imem_addr, RESET_PC);
    checkOutput("rstInst", inst, NOP);
    checkOutput("rstPc", PC_o, RESET_PC);
    checkOutput("rstValid", inst_valid, 0);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("rstFetchCnt", fetch_cnt, 0);
    checkOutput("rstFlushCnt", flush_cnt, 0);
`endif
    memQ.delete();
    staleLeft = 0;
    expPc = RESET_PC;
    fetchModel = 0;
    flushModel = 0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("rstHeldReq", imem_req, 0);
    reset = 1'b1;
  endtask

  initial begin
    logic        found;
    logic [63:0] addrHold;
    CLK = 1'b0;
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = '0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    delivered = 0;
    #1;
    resetDut();

    // First request after release, then back-to-back 1-cycle responses.
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("reqAfterRelease", imem_req, 1);
    checkOutput("staleRespIgnored", inst_valid, 0);
    applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("firstInst", inst, 32'h0010_0093);
    checkOutput("firstPc", PC_o, 64'h0);
    checkOutput("firstValid", inst_valid, 1);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("secondInst", inst, 32'h0020_0113);
    checkOutput("secondPc", PC_o, 64'h4);

    // Three stalled cycles: output holds and requests run out of credit.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, '0, 1, 1);
      checkOutput("stallHoldInst", inst, 32'h0020_0113);
      checkOutput("stallHoldPc", PC_o, 64'h4);
      checkOutput("stallNoReq", imem_req, 0);
    end
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("resumePc8", PC_o, 64'h8);
    applyStimulus(0, 0, '0, 1, 1);
    checkOutput("resumePcC", PC_o, 64'hC);

    // Build two outstanding requests, then redirect to an unaligned target.
    repeat (4) applyStimulus(0, 0, '0, 1, 0);
    checkOutput("twoOutstanding", memQ.size(), 2);
    applyStimulus(0, 1, 64'h103, 1, 0);
    checkOutput("redirectNoReq", imem_req, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(0, 0, '0, 1, 1);
      if (inst_valid) found = 1'b1;
      else checkOutput("nopUntilTarget", inst, NOP);
    end
    checkOutput("targetReturned", found, 1);
    checkOutput("targetPc", PC_o, 64'h100);

    // Branch together with stall still redirects.
    repeat (3) applyStimulus(0, 0, '0, 1, 1);
    applyStimulus(1, 1, 64'h200, 1, 1);
    checkOutput("stallBranchInst", inst, NOP);
    checkOutput("stallBranchValid", inst_valid, 0);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      applyStimulus(0, 0, '0, 1, 1);
      if (inst_valid) found = 1'b1;
    end
    checkOutput("stallBranchReturned", found, 1);
    checkOutput("stallBranchPc", PC_o, 64'h200);

    // Memory not ready for five cycles.
    addrHold = imem_addr;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, '0, 0, 1);
      checkOutput("notReadyAddr", imem_addr, addrHold);
    end
    checkOutput("drainedValid", inst_valid, 0);

    // Asynchronous reset in the middle of a stream.
    repeat (4) applyStimulus(0, 0, '0, 1, 1);
    resetDut();
    repeat (6) applyStimulus(0, 0, '0, 1, 1);

    // Randomized traffic against the program-order model.
    delivered = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) resetDut();
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
                    {48'h0, 16'($urandom)}, $urandom_range(0, 3) != 0, 2);
    end
    checkOutput("progress", delivered > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
